// File: rtl/dig_spi_responder.sv
`default_nettype none
// ============================================================================
// dig_spi_responder : serial (sen/sclk/sdata) register slave with readback
// Rev 1.0
// ============================================================================
module dig_spi_responder #(
   parameter int N_REGS      = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sen,
   input  logic                  sclk,
   input  logic                  sdata,
   output logic                  sdout,
   output logic [8*N_REGS-1:0]   reg_q,
   output logic                  wr_stb,
   output logic [6:0]            wr_addr,
   output logic [7:0]            wr_data,
   output logic                  frame_err
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [SYNC_STAGES-1:0] r_sen_sync;
   logic [SYNC_STAGES-1:0] r_sclk_sync;
   logic [SYNC_STAGES-1:0] r_sdata_sync;
   logic                   r_sen_d;
   logic                   r_sclk_d;

   logic                   w_sen;
   logic                   w_sclk;
   logic                   w_sdata;
   logic                   w_sen_fall;
   logic                   w_sen_rise;
   logic                   w_sclk_rise;
   logic                   w_sclk_fall;
   logic                   w_sclk_samp;

   logic [4:0]             r_bit_cnt;
   logic [14:0]            r_shift_in;
   logic [7:0]             r_out_sh;
   logic                   r_rd_act;
   logic [8*N_REGS-1:0]    r_reg_q;
   logic                   r_wr_stb;
   logic [6:0]             r_wr_addr;
   logic [7:0]             r_wr_data;
   logic                   r_frame_err;

   logic                   w_start;
   logic                   w_sample;
   logic                   w_hdr_done;
   logic                   w_last;
   logic                   w_abort;
   logic                   w_overlong;
   logic                   w_out_shift;
   logic                   w_enter_idle;
   logic [15:0]            w_word;
   logic                   w_hdr_rd;
   logic [6:0]             w_hdr_addr;
   logic [7:0]             w_rd_byte;
   logic                   w_wr_accept;
   logic                   w_soft_rst;

   // Pin synchronizers; reset values match the idle pin levels
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sen_sync   <= '1;
         r_sclk_sync  <= '1;
         r_sdata_sync <= '0;
         r_sen_d      <= 1'b1;
         r_sclk_d     <= 1'b1;
      end else begin
         r_sen_sync   <= {r_sen_sync[SYNC_STAGES-2:0], sen};
         r_sclk_sync  <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
         r_sdata_sync <= {r_sdata_sync[SYNC_STAGES-2:0], sdata};
         r_sen_d      <= w_sen;
         r_sclk_d     <= w_sclk;
      end
   end

   assign w_sen       = r_sen_sync[SYNC_STAGES-1];
   assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
   assign w_sdata     = r_sdata_sync[SYNC_STAGES-1];
   assign w_sen_fall  = r_sen_d & ~w_sen;
   assign w_sen_rise  = ~r_sen_d & w_sen;
   assign w_sclk_rise = ~r_sclk_d & w_sclk;
   assign w_sclk_fall = r_sclk_d & ~w_sclk;
   assign w_sclk_samp = w_sclk_rise & ~w_sen;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_sample    = 1'b0;
      w_hdr_done  = 1'b0;
      w_last      = 1'b0;
      w_abort     = 1'b0;
      w_overlong  = 1'b0;
      w_out_shift = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_sen_fall) begin
               w_state_nxt = ST_SHIFT;
               w_start     = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (w_sen_rise) begin
               w_state_nxt = ST_IDLE;
               w_abort     = 1'b1;
            end else begin
               if (w_sclk_samp) begin
                  w_sample = 1'b1;
                  if (r_bit_cnt == 5'd7) begin
                     w_hdr_done = 1'b1;
                  end
                  if (r_bit_cnt == 5'd15) begin
                     w_last      = 1'b1;
                     w_state_nxt = ST_HOLD;
                  end
               end
               // The falling edge right after the load must not shift, so that bit7 is seen at rising edge 9
               if (w_sclk_fall && r_rd_act && (r_bit_cnt > 5'd8)) begin
                  w_out_shift = 1'b1;
               end
            end
         end
         ST_HOLD: begin
            if (w_sen_rise) begin
               w_state_nxt = ST_IDLE;
            end else if (w_sclk_samp) begin
               w_overlong = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign w_enter_idle = (r_state != ST_IDLE) && (w_state_nxt == ST_IDLE);
   assign w_word       = {r_shift_in, w_sdata};
   assign w_hdr_rd     = r_shift_in[6];
   assign w_hdr_addr   = {r_shift_in[5:0], w_sdata};
   assign w_wr_accept  = w_last & ~w_word[15];
   assign w_soft_rst   = (w_word[14:8] == 7'd0) & w_word[0];

   // Unimplemented addresses fall through to 8'h00
   always_comb begin
      w_rd_byte = 8'h00;
      for (int i = 0; i < N_REGS; i++) begin
         if (w_hdr_addr == 7'(i)) begin
            w_rd_byte = r_reg_q[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bit_cnt   <= '0;
         r_shift_in  <= '0;
         r_out_sh    <= '0;
         r_rd_act    <= 1'b0;
         r_reg_q     <= '0;
         r_wr_stb    <= 1'b0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
         r_frame_err <= 1'b0;
      end else begin
         r_wr_stb    <= 1'b0;
         r_frame_err <= 1'b0;
         if (w_start) begin
            r_bit_cnt  <= '0;
            r_shift_in <= '0;
            r_out_sh   <= '0;
            r_rd_act   <= 1'b0;
         end
         if (w_sample) begin
            r_bit_cnt  <= r_bit_cnt + 5'd1;
            r_shift_in <= w_word[14:0];
         end
         if (w_hdr_done && w_hdr_rd) begin
            r_out_sh <= w_rd_byte;
            r_rd_act <= 1'b1;
         end
         if (w_out_shift) begin
            r_out_sh <= {r_out_sh[6:0], 1'b0};
         end
         if (w_wr_accept) begin
            r_wr_stb  <= 1'b1;
            r_wr_addr <= w_word[14:8];
            r_wr_data <= w_word[7:0];
            if (w_soft_rst) begin
               r_reg_q <= '0;
            end else begin
               for (int i = 0; i < N_REGS; i++) begin
                  if (w_word[14:8] == 7'(i)) begin
                     r_reg_q[8*i +: 8] <= w_word[7:0];
                  end
               end
            end
         end
         if (w_abort || w_overlong) begin
            r_frame_err <= 1'b1;
         end
         if (w_enter_idle) begin
            r_rd_act <= 1'b0;
            r_out_sh <= '0;
         end
      end
   end

   assign sdout     = r_rd_act & r_out_sh[7];
   assign reg_q     = r_reg_q;
   assign wr_stb    = r_wr_stb;
   assign wr_addr   = r_wr_addr;
   assign wr_data   = r_wr_data;
   assign frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_dig_spi_responder.sv
`default_nettype none
// ============================================================================
// tb_dig_spi_responder : directed frame-table bench for dig_spi_responder
// Rev 1.0
// ============================================================================
module tb_dig_spi_responder;

   localparam int PH = 8;

   logic        clk;
   logic        rst;
   logic        sen;
   logic        sclk;
   logic        sdata;
   logic        sdout;
   logic [63:0] reg_q;
   logic        wr_stb;
   logic [6:0]  wr_addr;
   logic [7:0]  wr_data;
   logic        frame_err;

   int          n_checks;
   int          n_errors;
   int          wr_cnt;
   int          ferr_cnt;
   logic [6:0]  last_addr;
   logic [7:0]  last_data;

   dig_spi_responder #(
      .N_REGS      (8),
      .SYNC_STAGES (2)
   ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .sen       (sen),
      .sclk      (sclk),
      .sdata     (sdata),
      .sdout     (sdout),
      .reg_q     (reg_q),
      .wr_stb    (wr_stb),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .frame_err (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wr_stb) begin
         wr_cnt    = wr_cnt + 1;
         last_addr = wr_addr;
         last_data = wr_data;
      end
      if (frame_err) begin
         ferr_cnt = ferr_cnt + 1;
      end
   end

   typedef struct {
      logic [15:0] word;
      int          edges;
      logic [15:0] exp_sd;
      int          exp_wr;
      logic [6:0]  exp_addr;
      logic [7:0]  exp_data;
      int          exp_ferr;
      logic [63:0] exp_reg;
   } vec_t;

   vec_t vecs [15];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks = n_checks + 1;
      if (act !== exp) begin
         n_errors = n_errors + 1;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // sdout is captured just before each rising sclk, where the master samples it
   task automatic do_frame(input logic [15:0] w, input int nedges, output logic [15:0] rd);
      rd = '0;
      @(negedge clk);
      sen = 1'b0;
      repeat (PH) @(negedge clk);
      for (int k = 0; k < nedges; k++) begin
         sclk  = 1'b0;
         sdata = (k < 16) ? w[15-k] : 1'b0;
         repeat (PH) @(negedge clk);
         if (k < 16) rd[15-k] = sdout;
         sclk = 1'b1;
         repeat (PH) @(negedge clk);
      end
      sen = 1'b1;
      repeat (PH) @(negedge clk);
   endtask

   initial begin
      logic [15:0] rd;
      logic [15:0] w;
      int          wr0;
      int          f0;

      n_checks = 0;
      n_errors = 0;
      wr_cnt   = 0;
      ferr_cnt = 0;
      last_addr = '0;
      last_data = '0;
      rst   = 1'b1;
      sen   = 1'b1;
      sclk  = 1'b1;
      sdata = 1'b0;

      vecs[0]  = '{16'h0312, 16, 16'h0000, 1, 7'd3,  8'h12, 0, 64'h0000_0000_1200_0000};
      vecs[1]  = '{16'h8300, 16, 16'h0012, 0, 7'd0,  8'h00, 0, 64'h0000_0000_1200_0000};
      vecs[2]  = '{16'hFF00, 16, 16'h0000, 0, 7'd0,  8'h00, 0, 64'h0000_0000_1200_0000};
      vecs[3]  = '{16'h05AA, 16, 16'h0000, 1, 7'd5,  8'hAA, 0, 64'h0000_AA00_1200_0000};
      vecs[4]  = '{16'h8500, 16, 16'h00AA, 0, 7'd0,  8'h00, 0, 64'h0000_AA00_1200_0000};
      vecs[5]  = '{16'h0001, 16, 16'h0000, 1, 7'd0,  8'h01, 0, 64'h0000_0000_0000_0000};
      vecs[6]  = '{16'h02CC, 10, 16'h0000, 0, 7'd0,  8'h00, 1, 64'h0000_0000_0000_0000};
      vecs[7]  = '{16'h02CC, 16, 16'h0000, 1, 7'd2,  8'hCC, 0, 64'h0000_0000_00CC_0000};
      vecs[8]  = '{16'h0155, 18, 16'h0000, 1, 7'd1,  8'h55, 2, 64'h0000_0000_00CC_5500};
      vecs[9]  = '{16'h0A77, 16, 16'h0000, 1, 7'd10, 8'h77, 0, 64'h0000_0000_00CC_5500};
      vecs[10] = '{16'h8155, 16, 16'h0055, 0, 7'd0,  8'h00, 0, 64'h0000_0000_00CC_5500};
      vecs[11] = '{16'h07F0, 16, 16'h0000, 1, 7'd7,  8'hF0, 0, 64'hF000_0000_00CC_5500};
      vecs[12] = '{16'h8700, 16, 16'h00F0, 0, 7'd0,  8'h00, 0, 64'hF000_0000_00CC_5500};
      vecs[13] = '{16'h820F, 12, 16'h00C0, 0, 7'd0,  8'h00, 1, 64'hF000_0000_00CC_5500};
      vecs[14] = '{16'h8200, 16, 16'h00CC, 0, 7'd0,  8'h00, 0, 64'hF000_0000_00CC_5500};

      repeat (4) @(negedge clk);
      check("reset reg_q",     reg_q,           64'h0);
      check("reset sdout",     64'(sdout),      64'h0);
      check("reset wr_stb",    64'(wr_stb),     64'h0);
      check("reset frame_err", 64'(frame_err),  64'h0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      for (int v = 0; v < 15; v++) begin
         wr0 = wr_cnt;
         f0  = ferr_cnt;
         do_frame(vecs[v].word, vecs[v].edges, rd);
         check($sformatf("v%0d sdout bits", v), 64'(rd), 64'(vecs[v].exp_sd));
         check($sformatf("v%0d wr_stb count", v), 64'(wr_cnt - wr0), 64'(vecs[v].exp_wr));
         check($sformatf("v%0d frame_err count", v), 64'(ferr_cnt - f0), 64'(vecs[v].exp_ferr));
         check($sformatf("v%0d reg_q", v), reg_q, vecs[v].exp_reg);
         check($sformatf("v%0d idle sdout", v), 64'(sdout), 64'h0);
         if (vecs[v].exp_wr > 0) begin
            check($sformatf("v%0d wr_addr", v), 64'(last_addr), 64'(vecs[v].exp_addr));
            check($sformatf("v%0d wr_data", v), 64'(last_data), 64'(vecs[v].exp_data));
         end
      end

      // Reset in the middle of a write frame: no write, no frame_err
      wr0 = wr_cnt;
      f0  = ferr_cnt;
      w   = 16'h0344;
      sen = 1'b0;
      repeat (PH) @(negedge clk);
      for (int k = 0; k < 6; k++) begin
         sclk  = 1'b0;
         sdata = w[15-k];
         repeat (PH) @(negedge clk);
         sclk = 1'b1;
         repeat (PH) @(negedge clk);
      end
      rst = 1'b1;
      repeat (2) @(negedge clk);
      sen = 1'b1;
      repeat (4) @(negedge clk);
      check("midrst reg_q",  reg_q,       64'h0);
      check("midrst sdout",  64'(sdout),  64'h0);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check("midrst wr_stb count",    64'(wr_cnt - wr0),   64'h0);
      check("midrst frame_err count", 64'(ferr_cnt - f0),  64'h0);

      wr0 = wr_cnt;
      do_frame(16'h0344, 16, rd);
      check("post-reset wr_stb count", 64'(wr_cnt - wr0), 64'h1);
      check("post-reset reg_q",        reg_q,             64'h0000_0000_4400_0000);
      check("post-reset frame_err",    64'(ferr_cnt - f0), 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dig_spi_responder.md
DIG_SPI_RESPONDER -- requirements
Module: dig_spi_responder

Interface
REQ-001 Parameter N_REGS, default 8: number of 8-bit registers implemented; legal 1..128.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth on each pin input; legal 2..4.
REQ-003 Port clk, input, 1: single system clock; all logic on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous, active-high.
REQ-005 Port sen, input, 1: serial enable pin, active-low, asynchronous to clk.
REQ-006 Port sclk, input, 1: serial clock pin, idle high, asynchronous to clk.
REQ-007 Port sdata, input, 1: serial data in, MSB first.
REQ-008 Port sdout, output, 1: serial readback data out.
REQ-009 Port reg_q, output, 8*N_REGS: register contents; reg n is bits [8n+7:8n].
REQ-010 Port wr_stb, output, 1: one-cycle pulse on each accepted register write.
REQ-011 Port wr_addr, output, 7: address of the accepted write, valid with wr_stb.
REQ-012 Port wr_data, output, 8: data of the accepted write, valid with wr_stb.
REQ-013 Port frame_err, output, 1: one-cycle pulse on an aborted or overlong frame.

Function
REQ-014 sen, sclk and sdata each pass through a SYNC_STAGES flip-flop synchronizer before use; edge detection uses the synchronized values only.
REQ-015 Frame format: 16 bits, MSB first; bit15 = R (1 = read), bits[14:8] = address, bits[7:0] = data, ignored for reads.
REQ-016 Data is sampled on each detected sclk rising edge while synchronized sen = 0.
REQ-017 Timing requirement on the serial master: sclk high and low phases each at least SYNC_STAGES+2 clk cycles.
REQ-018 FSM states: IDLE, SHIFT, HOLD.
REQ-019 FSM transitions:
- IDLE -> SHIFT on sen falling edge; bit counter cleared.
- SHIFT -> HOLD after the 16th sampled rising edge.
- SHIFT -> IDLE on sen rising edge, with frame_err pulsed.
- HOLD -> IDLE on sen rising edge.
REQ-020 5-bit bit counter; increments on each sampled rising edge in SHIFT.
REQ-021 Read load: after the 8th sampled rising edge with R = 1, an 8-bit output shifter loads reg[address]; an address >= N_REGS loads 8'h00. sdout shows the shifter MSB on the next clk cycle.
REQ-022 Read shift: in SHIFT, on each detected sclk falling edge after the load, the output shifter shifts left by one. Read data bits 7..0 are therefore valid for master sampling on sclk rising edges 9..16.
REQ-023 sdout is 0 in IDLE and during write frames. During a read, from the load through HOLD, sdout shows the shifter MSB; it returns to 0 when the FSM enters IDLE.
REQ-024 Write: on the 16th sampled rising edge with R = 0 and address < N_REGS, the write is accepted. One clk cycle later, reg[address] takes the data and wr_stb pulses with wr_addr and wr_data.
REQ-025 Write with address >= N_REGS: no register change, but wr_stb still pulses, with the decoded address.
REQ-026 Soft reset: an accepted write to address 0 with data bit0 = 1 sets all registers to 8'h00, including reg0, in the same cycle the write would complete. wr_stb still pulses.
REQ-027 Overlong frame: any sampled rising edge in HOLD pulses frame_err. It causes no register change and no sdout change.
REQ-028 Aborted frame (sen rising before 16 bits): no write is performed, the read shifter is discarded, and the FSM returns to IDLE.
REQ-029 A sen falling edge in HOLD is impossible without an intervening rising edge; a new frame always starts from IDLE.

Reset
REQ-030 While rst = 1:
- FSM in IDLE, counter and shifters 0.
- all registers 8'h00, sdout = 0, wr_stb = 0, frame_err = 0.
- synchronizer flops: sen = 1, sclk = 1, sdata = 0.
REQ-031 rst asserted mid-frame aborts the frame with no write and no frame_err. After release, the first frame decodes only after a fresh sen falling edge.

Verification
REQ-032 Write frame 0x0312 (addr 3, data 0x12) -> one wr_stb with wr_addr = 3, wr_data = 0x12; reg_q[31:24] = 0x12; all other bytes 0.
REQ-033 After REQ-032, read frame 0x8300 -> sdout presents 0,0,0,1,0,0,1,0 at sclk rising edges 9..16; no wr_stb; reg_q unchanged.
REQ-034 Read frame 0xFF00 (addr 127, >= N_REGS) -> sdout = 0 at all 16 edges; no wr_stb; no frame_err.
REQ-035 Write 0x05AA, then write 0x0001 -> after the second wr_stb, reg_q = 0 in every byte.
REQ-036 Write 0x02CC with sen raised after 10 sclk edges -> frame_err pulses once; no wr_stb; reg2 unchanged. A subsequent full 0x02CC frame writes normally.
REQ-037 Write 0x0155 with 18 sclk edges -> reg1 = 0x55 and wr_stb once; frame_err pulses twice, once per extra edge.
